writeback_stage: RTL
====================

Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback mux and register-file bypass; the write-side counterpart of the decode stage's register-file read path.
- Captures memory-stage results and drives the decode stage's register-file write port: RegWrite, WriteRegister, WriteData, ALUMemOrPC.
- Provides a same-cycle bypass so decode operand reads see a write still in flight.
- Keeps a saturating retired-instruction counter for debug.

Parameters:
- NBits, 32, datapath width.
- CNT_W, 32, width of RetiredCount.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hold the pipeline register.
- Flush  in  1  insert a bubble.
- in_Valid  in  1  memory-stage instruction is valid.
- in_RegWrite  in  1  instruction writes a register.
- in_MemtoReg  in  1  select load data.
- in_ALUMemOrPC  in  1  link write (jal): write PC+4 to r31.
- in_WriteRegister  in  5  destination register index.
- in_ALUResult  in  NBits  ALU result.
- in_MemReadData  in  NBits  load data.
- in_PCPlus4  in  NBits  link address.
- ReadRegister1, ReadRegister2  in  5  decode-stage read indices.
- RFReadData1, RFReadData2  in  NBits  raw register-file read data.
- RegWrite  out  1  register-file write enable.
- WriteRegister  out  5  raw destination index (decode substitutes 31 when ALUMemOrPC=1).
- ALUMemOrPC  out  1  link write flag.
- WriteData  out  NBits  register-file write data.
- Bypass1Data, Bypass2Data  out  NBits  forwarded operands for decode.
- Valid  out  1  stage holds a valid instruction.
- RetiredCount  out  CNT_W  instructions retired.

Behaviour:
- Reset (reset=0, asynchronous): all stored fields and RetiredCount clear to 0. Consequences: Valid=0, RegWrite=0, WriteRegister=0, ALUMemOrPC=0, WriteData=0, and BypassN=RFReadDataN.
- Register update at posedge clk, priority Flush > Stall > load:
  - Flush=1: Valid and RegWrite fields clear; data fields don't-care (held). Flush overrides Stall.
  - Stall=1, Flush=0: all fields hold.
  - Otherwise: all in_* fields load.
- Latency: 1 cycle from the memory-stage inputs to the outputs.
- Effective destination: EffDst = ALUMemOrPC ? 5'd31 : WriteRegister.
- RegWrite output = Valid & stored RegWrite & (EffDst != 0). Writes to r0 never assert RegWrite.
- WriteData selection:
  - ALUMemOrPC=1: PCPlus4.
  - Else MemtoReg=1: MemReadData.
  - Else: ALUResult.
  - The mux is combinational from the stored fields; no additional register.
- Bypass, per N in {1,2}: BypassNData = WriteData when RegWrite=1 and EffDst == ReadRegisterN; otherwise RFReadDataN.
  - ReadRegisterN=0 always returns RFReadDataN, which follows from the RegWrite rule.
  - Bypass is purely combinational from ReadRegisterN and RFReadDataN; no new registers.
- RetiredCount: increments at posedge when Valid=1, Stall=0 and Flush=0 (the instruction leaves the stage).
  - Saturates at all-ones and holds there.
  - Counts every valid instruction, including ones with RegWrite=0.
- Stall with Valid=1: RegWrite stays asserted for every stalled cycle. Rewriting the same value is idempotent and required.
- Reset asserted mid-operation: outputs drop to reset values immediately (asynchronous), not at the next clock edge.

Decomposition:
- Shared package: REG_ZERO=5'd0, REG_RA=5'd31, REG_IDX_W=5, and the writeback-select encoding (ALU/MEM/LINK).
- One natural sub-module, mem_wb_register: the flush/stall pipeline register holding all in_* fields.
- writeback_stage contains the mux, bypass compare and counter.

Test Plan:
- ALU write: in_Valid=1, in_RegWrite=1, in_WriteRegister=8, in_ALUResult=0x0000_0005 → next cycle RegWrite=1, WriteRegister=8, WriteData=5, RetiredCount=1 after the following edge.
- Load and link:
  - in_MemtoReg=1, in_MemReadData=0xDEAD_BEEF → WriteData=0xDEAD_BEEF.
  - Then in_ALUMemOrPC=1, in_PCPlus4=0x0040_0010 → WriteData=0x0040_0010, ALUMemOrPC=1, RegWrite=1.
- r0 suppression: in_WriteRegister=0, in_RegWrite=1 → RegWrite=0. With ReadRegister1=0, RFReadData1=0 → Bypass1Data=0.
- Bypass: stage holds write to r9 of 0x1234. ReadRegister1=9, RFReadData1=0x0 → Bypass1Data=0x1234. ReadRegister2=10, RFReadData2=0x77 → Bypass2Data=0x77.
- Stall/flush:
  - Stall=1 for 3 cycles while inputs change → outputs frozen, RetiredCount unchanged.
  - Stall=1 with Flush=1 → Valid=0, RegWrite=0 next cycle.
- Saturation and reset: CNT_W=3, retire 10 instructions → RetiredCount=7. Drop reset between edges → all outputs 0 without a clock edge.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline register and the writeback mux.
// Holds the register index constants and the writeback-select encoding.
package writeback_stage_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_IDX_W-1:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_MEM  = 2'd1,
        WB_SEL_LINK = 2'd2
    } wbSel_t;

    // A link write wins over a load, so jal always returns PC+4.
    function automatic wbSel_t wbSelect(input logic memtoReg, input logic aluMemOrPC);
        wbSel_t sel;
        sel = WB_SEL_ALU;
        if (aluMemOrPC) begin
            sel = WB_SEL_LINK;
        end else if (memtoReg) begin
            sel = WB_SEL_MEM;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register with flush/stall control.
// A flush drops only the valid and write-enable bits; the data fields hold.
module mem_wb_register
    import writeback_stage_pkg::*;
#(
    parameter int NBits = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 inValid,
    input  logic                 inRegWrite,
    input  logic                 inMemtoReg,
    input  logic                 inAluMemOrPC,
    input  logic [REG_IDX_W-1:0] inWriteRegister,
    input  logic [NBits-1:0]     inAluResult,
    input  logic [NBits-1:0]     inMemReadData,
    input  logic [NBits-1:0]     inPCPlus4,
    output logic                 qValid,
    output logic                 qRegWrite,
    output logic                 qMemtoReg,
    output logic                 qAluMemOrPC,
    output logic [REG_IDX_W-1:0] qWriteRegister,
    output logic [NBits-1:0]     qAluResult,
    output logic [NBits-1:0]     qMemReadData,
    output logic [NBits-1:0]     qPCPlus4
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qValid         <= 1'b0;
            qRegWrite      <= 1'b0;
            qMemtoReg      <= 1'b0;
            qAluMemOrPC    <= 1'b0;
            qWriteRegister <= '0;
            qAluResult     <= '0;
            qMemReadData   <= '0;
            qPCPlus4       <= '0;
        end else if (flush) begin
            qValid    <= 1'b0;
            qRegWrite <= 1'b0;
        end else if (!stall) begin
            qValid         <= inValid;
            qRegWrite      <= inRegWrite;
            qMemtoReg      <= inMemtoReg;
            qAluMemOrPC    <= inAluMemOrPC;
            qWriteRegister <= inWriteRegister;
            qAluResult     <= inAluResult;
            qMemReadData   <= inMemReadData;
            qPCPlus4       <= inPCPlus4;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB register, writeback mux, decode bypass and a
// saturating retired-instruction counter.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int NBits = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Stall,
    input  logic                 Flush,
    input  logic                 in_Valid,
    input  logic                 in_RegWrite,
    input  logic                 in_MemtoReg,
    input  logic                 in_ALUMemOrPC,
    input  logic [REG_IDX_W-1:0] in_WriteRegister,
    input  logic [NBits-1:0]     in_ALUResult,
    input  logic [NBits-1:0]     in_MemReadData,
    input  logic [NBits-1:0]     in_PCPlus4,
    input  logic [REG_IDX_W-1:0] ReadRegister1,
    input  logic [REG_IDX_W-1:0] ReadRegister2,
    input  logic [NBits-1:0]     RFReadData1,
    input  logic [NBits-1:0]     RFReadData2,
    output logic                 RegWrite,
    output logic [REG_IDX_W-1:0] WriteRegister,
    output logic                 ALUMemOrPC,
    output logic [NBits-1:0]     WriteData,
    output logic [NBits-1:0]     Bypass1Data,
    output logic [NBits-1:0]     Bypass2Data,
    output logic                 Valid,
    output logic [CNT_W-1:0]     RetiredCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                 qValid;
    logic                 qRegWrite;
    logic                 qMemtoReg;
    logic                 qAluMemOrPC;
    logic [REG_IDX_W-1:0] qWriteRegister;
    logic [NBits-1:0]     qAluResult;
    logic [NBits-1:0]     qMemReadData;
    logic [NBits-1:0]     qPCPlus4;
    logic [REG_IDX_W-1:0] effDst;

    mem_wb_register #(.NBits(NBits)) uMemWb (
        .clk             (clk),
        .reset           (reset),
        .stall           (Stall),
        .flush           (Flush),
        .inValid         (in_Valid),
        .inRegWrite      (in_RegWrite),
        .inMemtoReg      (in_MemtoReg),
        .inAluMemOrPC    (in_ALUMemOrPC),
        .inWriteRegister (in_WriteRegister),
        .inAluResult     (in_ALUResult),
        .inMemReadData   (in_MemReadData),
        .inPCPlus4       (in_PCPlus4),
        .qValid          (qValid),
        .qRegWrite       (qRegWrite),
        .qMemtoReg       (qMemtoReg),
        .qAluMemOrPC     (qAluMemOrPC),
        .qWriteRegister  (qWriteRegister),
        .qAluResult      (qAluResult),
        .qMemReadData    (qMemReadData),
        .qPCPlus4        (qPCPlus4)
    );

    // Decode forces r31 on link writes, so compares must use the same target.
    assign effDst        = qAluMemOrPC ? REG_RA : qWriteRegister;
    assign RegWrite      = qValid & qRegWrite & (effDst != REG_ZERO);
    assign WriteRegister = qWriteRegister;
    assign ALUMemOrPC    = qAluMemOrPC;
    assign Valid         = qValid;

    always_comb begin
        WriteData = qAluResult;
        case (wbSelect(qMemtoReg, qAluMemOrPC))
            WB_SEL_LINK: WriteData = qPCPlus4;
            WB_SEL_MEM:  WriteData = qMemReadData;
            default:     WriteData = qAluResult;
        endcase
    end

    assign Bypass1Data = (RegWrite && effDst == ReadRegister1) ? WriteData : RFReadData1;
    assign Bypass2Data = (RegWrite && effDst == ReadRegister2) ? WriteData : RFReadData2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RetiredCount <= '0;
        end else if (qValid && !Stall && !Flush && RetiredCount != CNT_MAX) begin
            RetiredCount <= RetiredCount + CNT_ONE;
        end
    end

endmodule
